// File: rtl/fns_eval_sched.sv
`default_nettype none
//============================================================================
// Module   : fns_eval_sched
// Brief    : Round-robin shared evaluator for the five port-typing functions.
//            NREQ requesters arbitrate for one registered evaluation stage;
//            results return in order through a credit-protected output FIFO
//            tagged with the requester index.
// Revision : 1.0 - initial release
//============================================================================
module fns_eval_sched #(
    parameter int NREQ  = 4,
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [3*NREQ-1:0]       req_op,
    input  logic [8*NREQ-1:0]       req_a,
    input  logic [8*NREQ-1:0]       req_b,
    output logic [NREQ-1:0]         req_ready,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [$clog2(NREQ)-1:0] rsp_id,
    output logic [7:0]              rsp_data,
    output logic                    rsp_err,
    output logic                    busy
);

    localparam int IDW = $clog2(NREQ);
    localparam int AW  = $clog2(DEPTH);
    localparam int CW  = AW + 1;
    localparam logic [CW-1:0]  C_DEPTH    = CW'(DEPTH);
    localparam logic [IDW:0]   C_NREQ     = (IDW+1)'(NREQ);
    localparam logic [IDW-1:0] C_LAST_REQ = IDW'(NREQ - 1);

    // Arbiter state and stage-1 pipeline register
    logic [IDW-1:0] r_ptr;
    logic           r_s1_valid;
    logic [2:0]     r_s1_op;
    logic [3:0]     r_s1_a;
    logic           r_s1_b;
    logic [IDW-1:0] r_s1_id;

    // Output FIFO storage and bookkeeping
    logic [7:0]     r_mem_data [DEPTH];
    logic           r_mem_err  [DEPTH];
    logic [IDW-1:0] r_mem_id   [DEPTH];
    logic [AW-1:0]  r_wptr;
    logic [AW-1:0]  r_rptr;
    logic [CW-1:0]  r_count;

    logic [CW-1:0]  w_space;
    logic           w_credit;
    logic [IDW:0]   w_sum;
    logic           w_found;
    logic [IDW-1:0] w_gidx;
    logic [NREQ-1:0] w_grant;
    logic           w_xfer;
    logic [7:0]     w_res;
    logic           w_err;
    logic           w_push;
    logic           w_pop;
    logic           w_head_valid;

    // Credit counts both stored entries and the one in flight in stage 1;
    // a same-cycle pop deliberately does not free a slot.
    assign w_space  = C_DEPTH - r_count - {{(CW-1){1'b0}}, r_s1_valid};
    assign w_credit = (w_space != '0);

    // Round-robin search starting at the pointer, wrapping modulo NREQ
    always_comb begin
        w_sum   = '0;
        w_found = 1'b0;
        w_gidx  = '0;
        w_grant = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_sum = {1'b0, r_ptr} + (IDW+1)'(k);
            if (w_sum >= C_NREQ) begin
                w_sum = w_sum - C_NREQ;
            end
            if (!w_found && req_valid[w_sum[IDW-1:0]]) begin
                w_found = 1'b1;
                w_gidx  = w_sum[IDW-1:0];
            end
        end
        if (w_found && w_credit) begin
            w_grant[w_gidx] = 1'b1;
        end
    end

    assign w_xfer    = w_found & w_credit;
    assign req_ready = w_grant;

    // Pointer advance and stage-1 capture of the granted request
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ptr      <= '0;
            r_s1_valid <= 1'b0;
            r_s1_op    <= '0;
            r_s1_a     <= '0;
            r_s1_b     <= 1'b0;
            r_s1_id    <= '0;
        end else begin
            r_s1_valid <= w_xfer;
            if (w_xfer) begin
                r_ptr   <= (w_gidx == C_LAST_REQ) ? '0 : w_gidx + 1'b1;
                r_s1_op <= req_op[3*w_gidx +: 3];
                r_s1_a  <= req_a[8*w_gidx +: 4];
                r_s1_b  <= req_b[8*w_gidx];
                r_s1_id <= w_gidx;
            end
        end
    end

    // Function evaluation on the stage-1 operands
    always_comb begin
        w_res = 8'h00;
        w_err = 1'b0;
        case (r_s1_op)
            3'd0:    w_res = {7'b0, r_s1_a[0] ^ r_s1_b};
            3'd1:    w_res = {4'b0, 1'b0, 1'b1, r_s1_a[0], r_s1_b};
            3'd2,
            3'd3:    w_res = {7'b0, r_s1_a[0] & r_s1_b};
            // Unsigned compare: only a[3:0]==0 with b=1 is "less than"
            3'd4:    w_res = {7'b0, (r_s1_a == 4'd0) && r_s1_b};
            default: begin
                w_res = 8'hFF;
                w_err = 1'b1;
            end
        endcase
    end

    assign w_head_valid = (r_count != '0);
    assign w_push       = r_s1_valid;
    assign w_pop        = w_head_valid & rsp_ready;

    // FIFO payload storage; contents are meaningless until counted
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_data[r_wptr] <= w_res;
            r_mem_err[r_wptr]  <= w_err;
            r_mem_id[r_wptr]   <= r_s1_id;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Head outputs are forced to zero while the FIFO is empty
    assign rsp_valid = w_head_valid;
    assign rsp_id    = w_head_valid ? r_mem_id[r_rptr]   : '0;
    assign rsp_data  = w_head_valid ? r_mem_data[r_rptr] : 8'h00;
    assign rsp_err   = w_head_valid ? r_mem_err[r_rptr]  : 1'b0;
    assign busy      = r_s1_valid | w_head_valid;

endmodule
`default_nettype wire

// File: tb/tb_fns_eval_sched.sv
`default_nettype none
//============================================================================
// Module   : tb_fns_eval_sched
// Brief    : Scoreboard bench for fns_eval_sched with directed vectors.
// Revision : 1.0 - initial release
//============================================================================
module tb_fns_eval_sched;

    localparam int NREQ  = 4;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [3:0]  req_valid = '0;
    logic [11:0] req_op = '0;
    logic [31:0] req_a = '0;
    logic [31:0] req_b = '0;
    logic [3:0]  req_ready;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [1:0]  rsp_id;
    logic [7:0]  rsp_data;
    logic        rsp_err;
    logic        busy;

    typedef struct packed {
        logic [1:0] id;
        logic [7:0] data;
        logic       err;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Per-requester vectors used by the multi-requester phases
    logic [7:0] v_exp [4];
    logic       v_err [4];

    fns_eval_sched #(.NREQ(NREQ), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        req_op[3*i +: 3] = op;
        req_a[8*i +: 8]  = a;
        req_b[8*i +: 8]  = b;
    endtask

    // Fixed vectors: r0 op1 -> 07, r1 op0 -> 01, r2 op5 -> FF/err, r3 op4 -> 01
    task automatic set_all_vectors();
        set_req(0, 3'd1, 8'h01, 8'h01); v_exp[0] = 8'h07; v_err[0] = 1'b0;
        set_req(1, 3'd0, 8'h00, 8'h01); v_exp[1] = 8'h01; v_err[1] = 1'b0;
        set_req(2, 3'd5, 8'h12, 8'h34); v_exp[2] = 8'hFF; v_err[2] = 1'b1;
        set_req(3, 3'd4, 8'h00, 8'h01); v_exp[3] = 8'h01; v_err[3] = 1'b0;
    endtask

    // Observe n grants; nibble g of seq is the expected grant index
    task automatic grant_run(input int n, input logic [31:0] seq, input int rdy_after, output int cyc);
        int g;
        logic [3:0] id;
        g   = 0;
        cyc = 0;
        while (g < n && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (req_ready != '0) begin
                id = seq[4*g +: 4];
                check("grant_onehot", {28'b0, req_ready}, 32'(1) << id);
                exp_q.push_back({id[1:0], v_exp[id], v_err[id]});
                g++;
            end
            @(posedge clk);
            #1;
            if (g == rdy_after) rsp_ready = 1'b1;
        end
        if (g < n) begin
            n_checks++;
            n_errors++;
            $display("FAIL grant_timeout: got %0d grants, required %0d", g, n);
        end
    endtask

    task automatic do_req(input int i, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] exp_d, input logic exp_e);
        int cyc;
        bit got;
        set_req(i, op, a, b);
        req_valid[i] = 1'b1;
        got = 1'b0;
        for (cyc = 0; cyc < 20 && !got; cyc++) begin
            @(negedge clk);
            if (req_ready[i]) begin
                got = 1'b1;
                exp_q.push_back({2'(i), exp_d, exp_e});
            end
        end
        n_checks++;
        if (!got) begin
            n_errors++;
            $display("FAIL do_req_timeout: got no grant, required grant to %0d", i);
        end
        @(posedge clk);
        #1;
        req_valid[i] = 1'b0;
    endtask

    task automatic wait_idle();
        int cyc;
        bit idle;
        idle = 1'b0;
        for (cyc = 0; cyc < 50 && !idle; cyc++) begin
            @(negedge clk);
            if (!busy && exp_q.size() == 0) idle = 1'b1;
        end
        if (!idle) begin
            n_checks++;
            n_errors++;
            $display("FAIL idle_timeout: busy=%0d pending=%0d, required idle", busy, exp_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare every accepted response against the scoreboard
    always @(negedge clk) begin
        exp_t e;
        if (reset_n && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL rsp_unexpected: got id %0d data %0h, required no response", rsp_id, rsp_data);
            end else begin
                e = exp_q.pop_front();
                check("rsp_id", {30'b0, rsp_id}, {30'b0, e.id});
                check("rsp_data", {24'b0, rsp_data}, {24'b0, e.data});
                check("rsp_err", {31'b0, rsp_err}, {31'b0, e.err});
            end
        end
    end

    initial begin
        int cyc;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        check("rst_req_ready", {28'b0, req_ready}, 32'h0);
        check("rst_rsp_valid", {31'b0, rsp_valid}, 32'h0);
        check("rst_busy", {31'b0, busy}, 32'h0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Single request, two-cycle latency
        set_req(0, 3'd0, 8'h01, 8'h01);
        req_valid = 4'b0001;
        exp_q.push_back({2'd0, 8'h00, 1'b0});
        @(negedge clk);
        check("t1_grant", {28'b0, req_ready}, 32'h1);
        @(posedge clk);
        #1;
        req_valid = '0;
        @(negedge clk);
        check("t1_lat_T1", {31'b0, rsp_valid}, 32'h0);
        check("t1_busy", {31'b0, busy}, 32'h1);
        @(negedge clk);
        check("t1_lat_T2", {31'b0, rsp_valid}, 32'h1);
        wait_idle();

        // Opcode sweep from requester 1
        do_req(1, 3'd1, 8'h01, 8'h00, 8'h06, 1'b0);
        do_req(1, 3'd2, 8'h0F, 8'h01, 8'h01, 1'b0);
        do_req(1, 3'd3, 8'h0E, 8'h01, 8'h00, 1'b0);
        do_req(1, 3'd4, 8'hF0, 8'h01, 8'h01, 1'b0);
        do_req(1, 3'd4, 8'h01, 8'h01, 8'h00, 1'b0);
        do_req(1, 3'd6, 8'h55, 8'hAA, 8'hFF, 1'b1);
        wait_idle();

        // Return pointer to 0, then round-robin with all requesters valid
        reset_n = 1'b0;
        #2;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        set_all_vectors();
        rsp_ready = 1'b1;
        req_valid = 4'b1111;
        grant_run(6, 32'h0010_3210, -1, cyc);
        check("rr_one_per_cycle", 32'(cyc), 32'd6);
        req_valid = '0;
        wait_idle();

        // Backpressure: exactly DEPTH transfers, then stall; pointer now 2
        rsp_ready = 1'b0;
        req_valid = 4'b1111;
        grant_run(4, 32'h0000_1032, -1, cyc);
        repeat (4) begin
            @(negedge clk);
            check("bp_stalled", {28'b0, req_ready}, 32'h0);
        end
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        grant_run(1, 32'h2, -1, cyc);
        req_valid = '0;
        wait_idle();

        // Simultaneous push/pop with three entries stored; pointer now 3
        rsp_ready = 1'b0;
        req_valid = 4'b1111;
        grant_run(4, 32'h0000_2103, 4, cyc);
        @(negedge clk);
        check("pp_head_valid", {31'b0, rsp_valid}, 32'h1);
        check("pp_no_credit", {28'b0, req_ready}, 32'h0);
        @(posedge clk);
        #1;
        grant_run(1, 32'h3, -1, cyc);
        req_valid = '0;
        wait_idle();

        // Reset while stage 1 and FIFO hold entries; pointer now 0
        rsp_ready = 1'b0;
        req_valid = 4'b1111;
        grant_run(3, 32'h0000_0210, -1, cyc);
        req_valid = '0;
        #1;
        reset_n = 1'b0;
        #1;
        check("mid_rst_rsp_valid", {31'b0, rsp_valid}, 32'h0);
        check("mid_rst_rsp_id", {30'b0, rsp_id}, 32'h0);
        check("mid_rst_rsp_data", {24'b0, rsp_data}, 32'h0);
        check("mid_rst_rsp_err", {31'b0, rsp_err}, 32'h0);
        check("mid_rst_busy", {31'b0, busy}, 32'h0);
        check("mid_rst_req_ready", {28'b0, req_ready}, 32'h0);
        exp_q.delete();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        rsp_ready = 1'b1;
        req_valid = 4'b0101;
        grant_run(1, 32'h0, -1, cyc);
        req_valid = '0;
        wait_idle();
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
